// File: rtl/trap_seq_controller_pkg.sv
// ---------------------------------------------------------------------------
// trap_seq_controller_pkg
// Shared definitions for the execute-stage sequencing / trap controller:
//   - PC_* next-PC mux encodings shared with the fetch stage
//   - FSM state encoding (IDLE / MULTI)
//   - trap cause codes and trap-vector offsets
//   - helpers for IRQ cause and vectored-mode offset
// ---------------------------------------------------------------------------
package trap_seq_controller_pkg;

    // Next-PC mux select
    localparam logic [1:0] PC_BRANCH_JUMP = 2'b00;
    localparam logic [1:0] PC_EXCEPTION   = 2'b01;
    localparam logic [1:0] PC_EPC         = 2'b10;

    typedef enum logic {
        StIdle  = 1'b0,
        StMulti = 1'b1
    } ctrl_state_e;

    // Trap cause codes (mcause encoding)
    localparam logic [4:0] CAUSE_ILLEGAL      = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK       = 5'd3;
    localparam logic [4:0] CAUSE_LSU_ERR      = 5'd5;
    localparam logic [4:0] CAUSE_ACCESS_FAULT = 5'd7;
    localparam logic [4:0] CAUSE_ECALL        = 5'd11;

    // Offsets added to the 128-byte aligned trap base
    localparam logic [6:0] OFF_ECALL        = 7'h04;
    localparam logic [6:0] OFF_ILLEGAL      = 7'h08;
    localparam logic [6:0] OFF_IRQ_DIRECT   = 7'h0C;
    localparam logic [6:0] OFF_LSU_ERR      = 7'h10;
    localparam logic [6:0] OFF_TIMEOUT      = 7'h14;
    localparam logic [6:0] OFF_EBREAK       = 7'h18;
    localparam logic [6:0] OFF_IRQ_VEC_BASE = 7'h40;

    // Interrupt k reports cause 16 + k
    function automatic logic [4:0] irq_cause(input logic [3:0] idx);
        return {1'b1, idx};
    endfunction

    // Vectored mode: line k jumps to 0x40 + 4k
    function automatic logic [6:0] irq_vec_offset(input logic [3:0] idx);
        return OFF_IRQ_VEC_BASE | {1'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/trap_seq_controller_if.sv
// ---------------------------------------------------------------------------
// trap_seq_controller_if
// Bundles every controller signal except clk/rst_n.
//   slave  : controller side (decode/handshake/IRQ inputs, control outputs)
//   master : pipeline side that drives the inputs and consumes the controls
// ---------------------------------------------------------------------------
interface trap_seq_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned CNT_WIDTH  = 4
) ();
    logic                  inst_valid_i;
    logic                  jump_inst_i;
    logic                  branch_inst_i;
    logic                  ecall_inst_i;
    logic                  ebreak_inst_i;
    logic                  mret_inst_i;
    logic                  illegal_inst_i;
    logic [NUM_IRQ-1:0]    irq_i;
    logic [NUM_IRQ-1:0]    irq_mask_i;
    logic                  irq_global_en_i;
    logic                  mm_start_i;
    logic                  mm_done_i;
    logic                  lsu_en_i;
    logic                  lsu_done_i;
    logic                  lsu_err_i;
    logic                  comp_result_i;
    logic [ADDR_WIDTH-1:0] tvec_i;
    logic                  tvec_mode_i;

    logic [CNT_WIDTH-1:0]  mc_count_o;
    logic                  rf_wen_allow_o;
    logic                  retire_o;
    logic [1:0]            pc_mux_sel_o;
    logic [ADDR_WIDTH-1:0] exc_pc_o;
    logic                  save_epc_o;
    logic [4:0]            cause_o;
    logic [NUM_IRQ-1:0]    irq_ack_o;
    logic                  target_valid_o;

    modport slave (
        input  inst_valid_i, jump_inst_i, branch_inst_i, ecall_inst_i, ebreak_inst_i,
        input  mret_inst_i, illegal_inst_i, irq_i, irq_mask_i, irq_global_en_i,
        input  mm_start_i, mm_done_i, lsu_en_i, lsu_done_i, lsu_err_i, comp_result_i,
        input  tvec_i, tvec_mode_i,
        output mc_count_o, rf_wen_allow_o, retire_o, pc_mux_sel_o, exc_pc_o,
        output save_epc_o, cause_o, irq_ack_o, target_valid_o
    );

    modport master (
        output inst_valid_i, jump_inst_i, branch_inst_i, ecall_inst_i, ebreak_inst_i,
        output mret_inst_i, illegal_inst_i, irq_i, irq_mask_i, irq_global_en_i,
        output mm_start_i, mm_done_i, lsu_en_i, lsu_done_i, lsu_err_i, comp_result_i,
        output tvec_i, tvec_mode_i,
        input  mc_count_o, rf_wen_allow_o, retire_o, pc_mux_sel_o, exc_pc_o,
        input  save_epc_o, cause_o, irq_ack_o, target_valid_o
    );

endinterface

// File: rtl/trap_seq_controller_irq_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_seq_controller_irq_prio_enc
// Fixed-priority interrupt encoder: the lowest-numbered pending line wins.
//   i_irq_req   : masked pending lines (irq & mie)
//   i_global_en : global enable (mstatus.MIE); 0 suppresses every line
//   o_any_valid : some line is taken
//   o_index     : index of the winning line
//   o_ack       : one-hot of the winning line
// ---------------------------------------------------------------------------
module trap_seq_controller_irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] i_irq_req,
    input  logic               i_global_en,
    output logic               o_any_valid,
    output logic [3:0]         o_index,
    output logic [NUM_IRQ-1:0] o_ack
);

    always_comb begin
        o_any_valid = 1'b0;
        o_index     = '0;
        o_ack       = '0;
        if (i_global_en) begin
            // Scan high to low so the lowest set line is written last
            for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
                if (i_irq_req[i]) begin
                    o_any_valid = 1'b1;
                    o_index     = 4'(i);
                    o_ack       = '0;
                    o_ack[i]    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trap_seq_controller.sv
// ---------------------------------------------------------------------------
// trap_seq_controller
// Execute-stage sequencing and trap controller for the RV32 core.
// Two states: IDLE issues single-cycle work or takes traps, MULTI waits for
// mul/div or load/store completion (and resolves jump/branch targets).
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : trap_seq_controller_if.slave -- decode flags, IRQ lines, mul/div
//           and LSU handshakes, trap base/mode in; PC mux select, trap target,
//           EPC save, cause, IRQ ack, RF write gate, retire, target valid and
//           MULTI cycle count out.
//
// Build option: define TRAP_SEQ_TIMEOUT_EN to raise an access-fault trap when
// a MULTI stall reaches MC_TIMEOUT cycles. Without it the stall is unbounded
// and the cycle count saturates.
// ---------------------------------------------------------------------------
module trap_seq_controller
    import trap_seq_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned MC_TIMEOUT = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trap_seq_controller_if.slave bus
);

    if ((NUM_IRQ < 1) || (NUM_IRQ > 16) || (MC_TIMEOUT >= (1 << CNT_WIDTH))) begin : g_bad_param
        $error("trap_seq_controller: NUM_IRQ or MC_TIMEOUT out of range");
    end

    ctrl_state_e           r_cs;
    ctrl_state_e           w_ns;
    logic [CNT_WIDTH-1:0]  r_mc_count;
    logic [CNT_WIDTH-1:0]  w_mc_count_next;

    logic [NUM_IRQ-1:0]    w_irq_pend;
    logic                  w_irq_any;
    logic [3:0]            w_irq_idx;
    logic [NUM_IRQ-1:0]    w_irq_onehot;

    logic                  w_stall;
    logic                  w_trap;
    logic [4:0]            w_cause;
    logic [6:0]            w_offset;
    logic                  w_rf_wen;
    logic                  w_retire;
    logic [1:0]            w_pc_sel;
    logic                  w_target_valid;
    logic [NUM_IRQ-1:0]    w_irq_ack;
    logic [ADDR_WIDTH-1:0] w_base;

    assign w_irq_pend = bus.irq_i & bus.irq_mask_i;

    trap_seq_controller_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_prio_enc (
        .i_irq_req   (w_irq_pend),
        .i_global_en (bus.irq_global_en_i),
        .o_any_valid (w_irq_any),
        .o_index     (w_irq_idx),
        .o_ack       (w_irq_onehot)
    );

    // Trap base is tvec aligned down to 128 bytes
    assign w_base  = bus.tvec_i & ~ADDR_WIDTH'(7'h7F);

    assign w_stall = (bus.lsu_en_i & ~bus.lsu_done_i) | (bus.mm_start_i & ~bus.mm_done_i);

    always_comb begin
        w_ns           = r_cs;
        w_trap         = 1'b0;
        w_cause        = '0;
        w_offset       = '0;
        w_rf_wen       = 1'b0;
        w_retire       = bus.inst_valid_i & ~bus.illegal_inst_i;
        w_pc_sel       = PC_BRANCH_JUMP;
        w_target_valid = 1'b0;
        w_irq_ack      = '0;

        if (bus.inst_valid_i) begin
            w_rf_wen = 1'b1;
            unique case (r_cs)
                StIdle: begin
                    if (w_irq_any) begin
                        w_trap    = 1'b1;
                        w_cause   = irq_cause(w_irq_idx);
                        w_offset  = bus.tvec_mode_i ? irq_vec_offset(w_irq_idx) : OFF_IRQ_DIRECT;
                        w_irq_ack = w_irq_onehot;
                        w_retire  = 1'b0;
                    end else if (bus.lsu_en_i) begin
                        if (bus.lsu_err_i) begin
                            w_trap   = 1'b1;
                            w_cause  = CAUSE_LSU_ERR;
                            w_offset = OFF_LSU_ERR;
                        end else begin
                            w_rf_wen = 1'b0;
                            w_retire = 1'b0;
                            w_ns     = StMulti;
                        end
                    end else if (bus.mm_start_i || bus.jump_inst_i) begin
                        w_retire = 1'b0;
                        w_ns     = StMulti;
                    end else if (bus.branch_inst_i) begin
                        // Taken branch resolves its target in MULTI
                        if (bus.comp_result_i) begin
                            w_retire = 1'b0;
                            w_ns     = StMulti;
                        end
                    end else if (bus.mret_inst_i) begin
                        w_pc_sel       = PC_EPC;
                        w_target_valid = 1'b1;
                        w_rf_wen       = 1'b0;
                    end else if (bus.ecall_inst_i) begin
                        w_trap   = 1'b1;
                        w_cause  = CAUSE_ECALL;
                        w_offset = OFF_ECALL;
                    end else if (bus.illegal_inst_i) begin
                        w_trap   = 1'b1;
                        w_cause  = CAUSE_ILLEGAL;
                        w_offset = OFF_ILLEGAL;
                    end else if (bus.ebreak_inst_i) begin
                        w_trap   = 1'b1;
                        w_cause  = CAUSE_EBREAK;
                        w_offset = OFF_EBREAK;
                        w_retire = 1'b0;
                    end
                end
                StMulti: begin
                    // IRQs and lsu_err are not looked at here; done beats err
                    if (w_stall) begin
                        w_rf_wen = 1'b0;
                        w_retire = 1'b0;
`ifdef TRAP_SEQ_TIMEOUT_EN
                        if (r_mc_count == CNT_WIDTH'(MC_TIMEOUT)) begin
                            w_trap   = 1'b1;
                            w_cause  = CAUSE_ACCESS_FAULT;
                            w_offset = OFF_TIMEOUT;
                            w_ns     = StIdle;
                        end
`endif
                    end else begin
                        w_ns           = StIdle;
                        w_target_valid = bus.jump_inst_i | bus.branch_inst_i;
                    end
                end
            endcase
        end

        if (w_trap) begin
            w_pc_sel       = PC_EXCEPTION;
            w_target_valid = 1'b1;
            w_rf_wen       = 1'b0;
        end
    end

    always_comb begin
        if (w_ns == StIdle) begin
            w_mc_count_next = '0;
        end else if (&r_mc_count) begin
            w_mc_count_next = r_mc_count;
        end else begin
            w_mc_count_next = r_mc_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs       <= StIdle;
            r_mc_count <= '0;
        end else begin
            r_cs       <= w_ns;
            r_mc_count <= w_mc_count_next;
        end
    end

    assign bus.mc_count_o     = r_mc_count;
    assign bus.rf_wen_allow_o = w_rf_wen;
    assign bus.retire_o       = w_retire;
    assign bus.pc_mux_sel_o   = w_pc_sel;
    assign bus.exc_pc_o       = w_trap ? (w_base | ADDR_WIDTH'(w_offset)) : '0;
    assign bus.save_epc_o     = w_trap;
    assign bus.cause_o        = w_trap ? w_cause : 5'd0;
    assign bus.irq_ack_o      = w_irq_ack;
    assign bus.target_valid_o = w_target_valid;

endmodule

// File: tb/tb_trap_seq_controller.sv
// Self-checking bench for trap_seq_controller: constant vector table, hand
// sequences for multi-cycle corners, then random stimulus against a model.
module tb_trap_seq_controller;
    import trap_seq_controller_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned NI  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned MCT = 12;
    localparam int          CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trap_seq_controller_if #(.ADDR_WIDTH(AW), .NUM_IRQ(NI), .CNT_WIDTH(CW)) bus ();

    trap_seq_controller #(
        .ADDR_WIDTH (AW),
        .NUM_IRQ    (NI),
        .CNT_WIDTH  (CW),
        .MC_TIMEOUT (MCT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid, jump, branch, ecall, ebreak, mret, illegal;
        logic [3:0]  irq, mask;
        logic        gie;
        logic        mm_start, mm_done, lsu_en, lsu_done, lsu_err, comp;
        logic [31:0] tvec;
        logic        mode;
    } stim_t;

    typedef struct packed {
        logic        rf, retire;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic        save;
        logic [4:0]  cause;
        logic [3:0]  ack;
        logic        tv;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   m_busy;
    int   m_cnt;
    vec_t tbl[$];

    function automatic exp_t ex(input logic rf, input logic retire, input logic [1:0] sel,
                                input logic [31:0] pc, input logic save, input logic [4:0] cause,
                                input logic [3:0] ack, input logic tv, input logic [3:0] cnt);
        exp_t e;
        e.rf = rf; e.retire = retire; e.sel = sel; e.pc = pc; e.save = save;
        e.cause = cause; e.ack = ack; e.tv = tv; e.cnt = cnt;
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("rf=%b ret=%b sel=%0d pc=%h save=%b cause=%0d ack=%b tv=%b cnt=%0d",
                         e.rf, e.retire, e.sel, e.pc, e.save, e.cause, e.ack, e.tv, e.cnt);
    endfunction

    // Valid plain instruction, all lines unmasked, tvec = 0x1234 (base 0x1200)
    function automatic stim_t base_s();
        stim_t s;
        s = '0;
        s.valid = 1'b1;
        s.mask  = 4'hF;
        s.tvec  = 32'h0000_1234;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.inst_valid_i    = s.valid;
        bus.jump_inst_i     = s.jump;
        bus.branch_inst_i   = s.branch;
        bus.ecall_inst_i    = s.ecall;
        bus.ebreak_inst_i   = s.ebreak;
        bus.mret_inst_i     = s.mret;
        bus.illegal_inst_i  = s.illegal;
        bus.irq_i           = s.irq;
        bus.irq_mask_i      = s.mask;
        bus.irq_global_en_i = s.gie;
        bus.mm_start_i      = s.mm_start;
        bus.mm_done_i       = s.mm_done;
        bus.lsu_en_i        = s.lsu_en;
        bus.lsu_done_i      = s.lsu_done;
        bus.lsu_err_i       = s.lsu_err;
        bus.comp_result_i   = s.comp;
        bus.tvec_i          = s.tvec;
        bus.tvec_mode_i     = s.mode;
    endtask

    task automatic check(input string name, input exp_t e);
        exp_t g;
        g = ex(bus.rf_wen_allow_o, bus.retire_o, bus.pc_mux_sel_o, bus.exc_pc_o,
               bus.save_epc_o, bus.cause_o, bus.irq_ack_o, bus.target_valid_o, bus.mc_count_o);
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s", name, fmt(g), fmt(e));
        end
    endtask

    // Called at posedge+1: drive, sample at posedge+3, advance one clock
    task automatic cycle(input string name, input stim_t s, input exp_t e);
        drive(s);
        #2;
        check(name, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(base_s());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_cnt  = 0;
    endtask

    // Reference model: the rules read straight off the behaviour description
    function automatic exp_t model(input stim_t s, input bit busy, input int cnt,
                                   output bit busy_n);
        exp_t e;
        bit   trap;
        int   cause, off, k;
        e        = '0;
        e.sel    = PC_BRANCH_JUMP;
        e.retire = s.valid & ~s.illegal;
        e.cnt    = 4'(cnt);
        trap     = 1'b0;
        cause    = 0;
        off      = 0;
        busy_n   = busy;
        if (s.valid) begin
            e.rf = 1'b1;
            if (busy) begin
                if ((s.lsu_en && !s.lsu_done) || (s.mm_start && !s.mm_done)) begin
                    e.rf     = 1'b0;
                    e.retire = 1'b0;
`ifdef TRAP_SEQ_TIMEOUT_EN
                    if (cnt == int'(MCT)) begin
                        trap = 1'b1; cause = 7; off = 'h14; busy_n = 1'b0;
                    end
`endif
                end else begin
                    busy_n = 1'b0;
                    e.tv   = s.jump | s.branch;
                end
            end else begin
                k = -1;
                if (s.gie) begin
                    for (int i = 3; i >= 0; i--) if (s.irq[i] && s.mask[i]) k = i;
                end
                if (k >= 0) begin
                    trap = 1'b1; cause = 16 + k;
                    off = s.mode ? ('h40 + 4 * k) : 'h0C;
                    e.ack[k] = 1'b1;
                    e.retire = 1'b0;
                end else if (s.lsu_en) begin
                    if (s.lsu_err) begin
                        trap = 1'b1; cause = 5; off = 'h10;
                    end else begin
                        e.rf = 1'b0; e.retire = 1'b0; busy_n = 1'b1;
                    end
                end else if (s.mm_start || s.jump) begin
                    e.retire = 1'b0; busy_n = 1'b1;
                end else if (s.branch) begin
                    if (s.comp) begin
                        e.retire = 1'b0; busy_n = 1'b1;
                    end
                end else if (s.mret) begin
                    e.sel = PC_EPC; e.tv = 1'b1; e.rf = 1'b0;
                end else if (s.ecall) begin
                    trap = 1'b1; cause = 11; off = 'h04;
                end else if (s.illegal) begin
                    trap = 1'b1; cause = 2; off = 'h08;
                end else if (s.ebreak) begin
                    trap = 1'b1; cause = 3; off = 'h18; e.retire = 1'b0;
                end
            end
        end
        if (trap) begin
            e.sel   = PC_EXCEPTION;
            e.tv    = 1'b1;
            e.save  = 1'b1;
            e.rf    = 1'b0;
            e.pc    = (s.tvec / 32'd128) * 32'd128 + 32'(off);
            e.cause = 5'(cause);
        end
        return e;
    endfunction

    task automatic rand_cycle(input string name, input stim_t s);
        exp_t e;
        bit   bn;
        e = model(s, m_busy, m_cnt, bn);
        cycle(name, s, e);
        m_busy = bn;
        m_cnt  = m_busy ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX) : 0;
    endtask

    function automatic stim_t rand_s();
        stim_t s;
        s.valid    = ($urandom_range(9) != 0);
        s.jump     = ($urandom_range(7) == 0);
        s.branch   = ($urandom_range(5) == 0);
        s.ecall    = ($urandom_range(7) == 0);
        s.ebreak   = ($urandom_range(7) == 0);
        s.mret     = ($urandom_range(7) == 0);
        s.illegal  = ($urandom_range(9) == 0);
        s.irq      = 4'($urandom);
        s.mask     = 4'($urandom);
        s.gie      = ($urandom_range(3) == 0);
        s.mm_start = ($urandom_range(4) == 0);
        s.mm_done  = ($urandom_range(2) == 0);
        s.lsu_en   = ($urandom_range(4) == 0);
        s.lsu_done = ($urandom_range(2) == 0);
        s.lsu_err  = ($urandom_range(5) == 0);
        s.comp     = ($urandom_range(1) == 0);
        s.tvec     = $urandom;
        s.mode     = ($urandom_range(1) == 0);
        return s;
    endfunction

    task automatic add(input string name, input stim_t s, input exp_t e);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.e    = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;

        // Single-cycle IDLE cases; none of these leave IDLE
        s = base_s(); s.ecall = 1'b1;
        add("ecall", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0, 1'b1, 4'd0));
        s = base_s(); s.irq = 4'b1010; s.gie = 1'b1; s.mode = 1'b1;
        add("irq vectored", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h1244, 1'b1, 5'd17, 4'b0010,
                                  1'b1, 4'd0));
        s.mode = 1'b0;
        add("irq direct", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h120C, 1'b1, 5'd17, 4'b0010,
                                1'b1, 4'd0));
        s = base_s(); s.irq = 4'b1010; s.ecall = 1'b1;
        add("irq gie off", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0, 1'b1,
                                 4'd0));
        s = base_s(); s.irq = 4'b1000; s.mask = 4'b0111; s.gie = 1'b1; s.ecall = 1'b1;
        add("irq masked", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0, 1'b1,
                                4'd0));
        s = base_s(); s.irq = 4'b1000; s.gie = 1'b1; s.mode = 1'b1;
        add("irq line3 vec", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h124C, 1'b1, 5'd19, 4'b1000,
                                   1'b1, 4'd0));
        s = base_s(); s.lsu_en = 1'b1; s.lsu_err = 1'b1;
        add("lsu err", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1210, 1'b1, 5'd5, 4'b0, 1'b1, 4'd0));
        s = base_s(); s.illegal = 1'b1;
        add("illegal", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h1208, 1'b1, 5'd2, 4'b0, 1'b1, 4'd0));
        s = base_s(); s.ebreak = 1'b1;
        add("ebreak", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h1218, 1'b1, 5'd3, 4'b0, 1'b1, 4'd0));
        s = base_s(); s.mret = 1'b1;
        add("mret", s, ex(1'b0, 1'b1, PC_EPC, 32'h0, 1'b0, 5'd0, 4'b0, 1'b1, 4'd0));
        s = base_s();
        add("plain alu", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        s = base_s(); s.branch = 1'b1;
        add("branch not taken", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                      4'd0));
        s = base_s(); s.valid = 1'b0; s.ecall = 1'b1; s.irq = 4'hF; s.gie = 1'b1;
        add("invalid", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        s = base_s(); s.ecall = 1'b1; s.illegal = 1'b1;
        add("ecall over illegal", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0,
                                        1'b1, 4'd0));
        s = base_s(); s.ecall = 1'b1; s.tvec = 32'hFFFF_FFFF;
        add("ecall high base", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'hFFFF_FF84, 1'b1, 5'd11, 4'b0,
                                     1'b1, 4'd0));
        s = base_s(); s.irq = 4'b0001; s.gie = 1'b1; s.mode = 1'b1; s.tvec = 32'hFFFF_FFFF;
        add("irq0 high base", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'hFFFF_FFC0, 1'b1, 5'd16, 4'b0001,
                                    1'b1, 4'd0));

        // Reset state
        drive(base_s());
        #3;
        check("reset state", ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) cycle(tbl[i].name, tbl[i].s, tbl[i].e);

        // Load: one stall, done (with err) on the third cycle
        s = base_s(); s.lsu_en = 1'b1;
        cycle("load issue", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        cycle("load stall", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd1));
        s.lsu_done = 1'b1; s.lsu_err = 1'b1;
        cycle("load done+err", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                     4'd2));
        s = base_s();
        cycle("after load", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));

        // Taken branch, then jump
        s = base_s(); s.branch = 1'b1; s.comp = 1'b1;
        cycle("br taken issue", s, ex(1'b1, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                      4'd0));
        cycle("br taken target", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b1,
                                       4'd1));
        s = base_s(); s.jump = 1'b1;
        cycle("jump issue", s, ex(1'b1, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        cycle("jump target", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b1,
                                   4'd1));

        // Long mul/div stall with IRQs pending (ignored in MULTI)
        s = base_s(); s.mm_start = 1'b1;
        cycle("mm issue", s, ex(1'b1, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0, 4'd0));
        s.irq = 4'hF; s.gie = 1'b1;
`ifdef TRAP_SEQ_TIMEOUT_EN
        for (int c = 1; c < int'(MCT); c++) begin
            cycle("mm stall", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                    4'(c)));
        end
        cycle("mm timeout", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h1214, 1'b1, 5'd7, 4'b0, 1'b1,
                                  4'd12));
`else
        for (int c = 1; c <= 17; c++) begin
            cycle("mm stall sat", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                        4'((c > CNT_MAX) ? CNT_MAX : c)));
        end
        s.mm_done = 1'b1;
        cycle("mm done sat", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                   4'd15));
`endif
        s = base_s(); s.irq = 4'hF; s.gie = 1'b1;
        cycle("irq after multi", s, ex(1'b0, 1'b0, PC_EXCEPTION, 32'h120C, 1'b1, 5'd16, 4'b0001,
                                       1'b1, 4'd0));

        // Asynchronous reset in the middle of MULTI
        s = base_s(); s.lsu_en = 1'b1;
        cycle("rst load issue", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                      4'd0));
        cycle("rst load stall", s, ex(1'b0, 1'b0, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                      4'd1));
        s = base_s(); s.ecall = 1'b1;
        drive(s);
        #1;
        check("multi ecall completes", ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0,
                                          1'b0, 4'd2));
        rst_n = 1'b0;
        #1;
        check("async rst to idle", ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0, 1'b1,
                                      4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("first inst after rst", s, ex(1'b0, 1'b1, PC_EXCEPTION, 32'h1204, 1'b1, 5'd11, 4'b0,
                                            1'b1, 4'd0));
        s = base_s();
        cycle("idle after rst", s, ex(1'b1, 1'b1, PC_BRANCH_JUMP, 32'h0, 1'b0, 5'd0, 4'b0, 1'b0,
                                      4'd0));

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 600; i++) rand_cycle("random", rand_s());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
